// File: rtl/mac_da_lookup_pkg.sv
// Shared definitions for the MAC table DA lookup path: default sizing, FSM
// state encoding and the {valid, port} table entry layout.
// No ports; imported by mac_da_lookup and mac_rr_arbiter users.
package mac_da_lookup_pkg;

  localparam int DEF_MAX_PORT_NUMBER = 4;
  localparam int DEF_SLOTS           = 4096;
  localparam int DEF_AW              = $clog2(DEF_SLOTS);            // 6+6 hashed DA bits
  localparam int DEF_PW              = $clog2(DEF_MAX_PORT_NUMBER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lookup_state_t;

  // One MAC table entry as stored by the learning path.
  typedef struct packed {
    logic              valid;
    logic [DEF_PW-1:0] port;
  } mac_entry_t;

endpackage

// File: rtl/mac_rr_arbiter.sv
// Round-robin pick: first set request bit at or above ptr, wrapping to 0.
// Latency: combinational. Backpressure: none; caller decides when to take the grant.
// Ports: req (request vector), ptr (search start), gnt (winning index), gnt_vld (any request).
module mac_rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt,
  output logic          gnt_vld
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt     = idx[PW-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_da_lookup.sv
// DA lookup: round-robin serves per-port requests against the MAC table, returns forwarding mask.
// Latency: req sampled in IDLE at T -> o_rd_en at T+1 -> o_da_ack at T+3; one lookup in flight.
// Backpressure: requests are levels held until ack; unserved ports simply wait their RR turn.
// Ports: iclk/irst_n (sync active-low); i_da_req/i_da_addr per-port requests; o_da_ack/o_dst_mask/
//        o_flood response; o_rd_en/o_rd_addr, i_rd_valid/i_rd_port table read; i_wr_* learn write snoop.
module mac_da_lookup
  import mac_da_lookup_pkg::*;
#(
  parameter  int pMAX_PORT_NUMBER = DEF_MAX_PORT_NUMBER,
  parameter  int pSLOTS           = DEF_SLOTS,
  localparam int AW               = $clog2(pSLOTS),
  localparam int PW               = $clog2(pMAX_PORT_NUMBER)
) (
  input  logic                          iclk,
  input  logic                          irst_n,
  input  logic [pMAX_PORT_NUMBER-1:0]    i_da_req,
  input  logic [pMAX_PORT_NUMBER*AW-1:0] i_da_addr,
  output logic [pMAX_PORT_NUMBER-1:0]    o_da_ack,
  output logic [pMAX_PORT_NUMBER-1:0]    o_dst_mask,
  output logic                          o_flood,
  output logic                          o_rd_en,
  output logic [AW-1:0]                 o_rd_addr,
  input  logic                          i_rd_valid,
  input  logic [PW-1:0]                 i_rd_port,
  input  logic                          i_wr_en,
  input  logic [AW-1:0]                 i_wr_addr,
  input  logic [PW-1:0]                 i_wr_port
);

  localparam logic [pMAX_PORT_NUMBER-1:0] ONE = {{(pMAX_PORT_NUMBER-1){1'b0}}, 1'b1};

  lookup_state_t                 state;
  logic [PW-1:0]                 rr_ptr;
  logic [PW-1:0]                 gidx;
  logic [AW-1:0]                 addr;
  logic                          byp_flag;
  logic [PW-1:0]                 byp_port;

  logic [PW-1:0]                 gnt;
  logic                          gnt_vld;
  logic [AW-1:0]                 req_addr;
  logic                          wr_hit;
  logic                          res_valid;
  logic [PW-1:0]                 res_port;
  logic [pMAX_PORT_NUMBER-1:0]   resp_mask;
  logic                          resp_flood;

  mac_rr_arbiter #(.N(pMAX_PORT_NUMBER)) u_arb (
    .req     (i_da_req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  assign req_addr  = i_da_addr[int'(gnt)*AW +: AW];
  assign wr_hit    = i_wr_en && (i_wr_addr == addr);
  assign o_rd_addr = addr;

  // Entry resolution in the WAIT cycle: a learn write to our address in this
  // cycle beats one captured during READ, which beats the RAM data (the RAM
  // read already happened and cannot see either write).
  always_comb begin
    res_valid = i_rd_valid;
    res_port  = i_rd_port;
    if (wr_hit) begin
      res_valid = 1'b1;
      res_port  = i_wr_port;
    end else if (byp_flag) begin
      res_valid = 1'b1;
      res_port  = byp_port;
    end
  end

  // Out-of-range port numbers are corrupt entries and are flooded like misses.
  always_comb begin
    resp_mask  = '0;
    resp_flood = 1'b0;
    if (!res_valid || (int'(res_port) >= pMAX_PORT_NUMBER)) begin
      resp_mask  = ~(ONE << gidx);
      resp_flood = 1'b1;
    end else if (res_port != gidx) begin
      resp_mask  = ONE << res_port;
    end
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      gidx       <= '0;
      addr       <= '0;
      byp_flag   <= 1'b0;
      byp_port   <= '0;
      o_rd_en    <= 1'b0;
      o_da_ack   <= '0;
      o_dst_mask <= '0;
      o_flood    <= 1'b0;
    end else begin
      o_rd_en    <= 1'b0;
      o_da_ack   <= '0;
      o_dst_mask <= '0;
      o_flood    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            gidx     <= gnt;
            addr     <= req_addr;
            byp_flag <= 1'b0;
            o_rd_en  <= 1'b1;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          if (wr_hit) begin
            byp_flag <= 1'b1;
            byp_port <= i_wr_port;
          end
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          o_da_ack   <= ONE << gidx;
          o_dst_mask <= resp_mask;
          o_flood    <= resp_flood;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          rr_ptr <= (int'(gidx) == pMAX_PORT_NUMBER - 1) ? '0 : gidx + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_da_lookup.sv
// Directed bench for mac_da_lookup: drives requests, plays the table RAM
// (data only in the cycle after o_rd_en) and snoops learn writes.
module tb_mac_da_lookup;

  localparam int N  = 4;
  localparam int AW = 12;

  logic            iclk = 1'b0;
  logic            irst_n;
  logic [N-1:0]    i_da_req;
  logic [N*AW-1:0] i_da_addr;
  logic [N-1:0]    o_da_ack;
  logic [N-1:0]    o_dst_mask;
  logic            o_flood;
  logic            o_rd_en;
  logic [AW-1:0]   o_rd_addr;
  logic            i_rd_valid;
  logic [1:0]      i_rd_port;
  logic            i_wr_en;
  logic [AW-1:0]   i_wr_addr;
  logic [1:0]      i_wr_port;

  bit       mem_v [4096];
  bit [1:0] mem_p [4096];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 iclk = ~iclk;

  mac_da_lookup dut (
    .iclk       (iclk),
    .irst_n     (irst_n),
    .i_da_req   (i_da_req),
    .i_da_addr  (i_da_addr),
    .o_da_ack   (o_da_ack),
    .o_dst_mask (o_dst_mask),
    .o_flood    (o_flood),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .i_rd_valid (i_rd_valid),
    .i_rd_port  (i_rd_port),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_port  (i_wr_port)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge iclk);
  endtask

  // Follows one lookup from its rd_en to its ack. byp_phase 1 drives a learn
  // write across the READ edge, 2 across the WAIT edge, 0 none.
  task automatic serve(input string tag, input logic [AW-1:0] exp_addr, input int exp_cyc,
                       input logic [N-1:0] exp_ack, input logic [N-1:0] exp_mask,
                       input logic exp_flood, input int byp_phase,
                       input logic [AW-1:0] w_addr, input logic [1:0] w_port);
    int n;
    logic [AW-1:0] a;
    n = 0;
    do begin
      @(negedge iclk);
      n++;
    end while (!o_rd_en && n < 12);
    chk({tag, "_rd_en"}, 32'(o_rd_en), 32'd1);
    chk({tag, "_rd_addr"}, 32'(o_rd_addr), 32'(exp_addr));
    a = o_rd_addr;
    if (byp_phase == 1) begin
      i_wr_en = 1'b1; i_wr_addr = w_addr; i_wr_port = w_port;
    end
    @(negedge iclk);
    n++;
    i_wr_en    = 1'b0;
    i_rd_valid = mem_v[a];
    i_rd_port  = mem_p[a];
    if (byp_phase == 2) begin
      i_wr_en = 1'b1; i_wr_addr = w_addr; i_wr_port = w_port;
    end
    chk({tag, "_rd_en_1cyc"}, 32'(o_rd_en), 32'd0);
    chk({tag, "_wait_quiet"}, {24'd0, o_da_ack, o_dst_mask}, 32'd0);
    @(negedge iclk);
    n++;
    i_wr_en    = 1'b0;
    i_rd_valid = ~mem_v[a];
    i_rd_port  = mem_p[a] + 2'd1;
    chk({tag, "_cyc"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_ack"}, 32'(o_da_ack), 32'(exp_ack));
    chk({tag, "_mask"}, 32'(o_dst_mask), 32'(exp_mask));
    chk({tag, "_flood"}, 32'(o_flood), 32'(exp_flood));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    irst_n = 1'b0; i_da_req = '0; i_da_addr = '0;
    i_wr_en = 1'b0; i_wr_addr = '0; i_wr_port = '0;
    i_rd_valid = 1'b1; i_rd_port = 2'd1;

    for (int q = 0; q < N; q++) begin
      mem_v[12'h300 + q] = 1'b1;
      mem_p[12'h300 + q] = 2'((q + 1) % N);
      i_da_addr[q*AW +: AW] = 12'(12'h300 + q);
    end
    mem_v[12'h2A5] = 1'b1; mem_p[12'h2A5] = 2'd3;
    mem_v[12'h155] = 1'b0; mem_p[12'h155] = 2'd1;
    mem_v[12'h0AA] = 1'b1; mem_p[12'h0AA] = 2'd2;
    mem_v[12'h3C3] = 1'b1; mem_p[12'h3C3] = 2'd0;
    mem_v[12'h010] = 1'b0; mem_p[12'h010] = 2'd1;
    mem_v[12'h011] = 1'b0; mem_p[12'h011] = 2'd1;

    // Reset held with all ports requesting.
    i_da_req = 4'b1111;
    repeat (3) begin
      @(negedge iclk);
      chk("rst_ack", 32'(o_da_ack), 32'd0);
      chk("rst_rd_en", 32'(o_rd_en), 32'd0);
      chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
      chk("rst_mask_flood", {27'd0, o_dst_mask, o_flood}, 32'd0);
    end
    irst_n = 1'b1;
    serve("rst_first", 12'h300, 3, 4'b0001, 4'b0010, 1'b0, 0, '0, '0);
    i_da_req = '0;
    idle(2);

    // Unicast, miss, self-hit, then port 3 to move the pointer back to 0.
    i_da_addr[1*AW +: AW] = 12'h2A5; i_da_req = 4'b0010;
    serve("ucast", 12'h2A5, 3, 4'b0010, 4'b1000, 1'b0, 0, '0, '0);
    i_da_req = '0; idle(2);
    i_da_addr[2*AW +: AW] = 12'h155; i_da_req = 4'b0100;
    serve("miss", 12'h155, 3, 4'b0100, 4'b1011, 1'b1, 0, '0, '0);
    i_da_req = '0; idle(2);
    i_da_addr[2*AW +: AW] = 12'h0AA; i_da_req = 4'b0100;
    serve("selfhit", 12'h0AA, 3, 4'b0100, 4'b0000, 1'b0, 0, '0, '0);
    i_da_req = '0; idle(2);
    i_da_addr[3*AW +: AW] = 12'h3C3; i_da_req = 4'b1000;
    serve("p3", 12'h3C3, 3, 4'b1000, 4'b0001, 1'b0, 0, '0, '0);
    i_da_req = '0; idle(2);

    // Round-robin with every port requesting: 0,1,2,3,0 back to back.
    for (int q = 0; q < N; q++) i_da_addr[q*AW +: AW] = 12'(12'h300 + q);
    i_da_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      p = k % N;
      serve($sformatf("rr%0d_p%0d", k, p), 12'(12'h300 + p), (k == 0) ? 3 : 4,
            4'(1 << p), 4'(1 << ((p + 1) % N)), 1'b0, 0, '0, '0);
    end
    // Pointer now at 1: port 3 must win over port 0.
    i_da_req = 4'b1001;
    serve("rr_wrap_p3", 12'h303, 4, 4'b1000, 4'b0001, 1'b0, 0, '0, '0);
    i_da_req = 4'b0001;
    serve("rr_wrap_p0", 12'h300, 4, 4'b0001, 4'b0010, 1'b0, 0, '0, '0);
    i_da_req = '0; idle(2);

    // Learn-write forwarding.
    i_da_addr[0 +: AW] = 12'h010; i_da_req = 4'b0001;
    serve("byp_wait_hit", 12'h010, 3, 4'b0001, 4'b0100, 1'b0, 2, 12'h010, 2'd2);
    i_da_req = '0; idle(2);
    i_da_req = 4'b0001;
    serve("byp_wait_other", 12'h010, 3, 4'b0001, 4'b1110, 1'b1, 2, 12'h011, 2'd2);
    i_da_req = '0; idle(2);
    i_da_req = 4'b0001;
    serve("byp_read_hit", 12'h010, 3, 4'b0001, 4'b1000, 1'b0, 1, 12'h010, 2'd3);
    i_da_req = '0; idle(2);

    // Reset landing on the WAIT edge drops the lookup; held request is re-served.
    i_da_addr[1*AW +: AW] = 12'h2A5; i_da_req = 4'b0010;
    @(negedge iclk);
    chk("mr_rd_en", 32'(o_rd_en), 32'd1);
    @(negedge iclk);
    irst_n = 1'b0;
    @(negedge iclk);
    chk("mr_no_ack", 32'(o_da_ack), 32'd0);
    chk("mr_mask_flood", {27'd0, o_dst_mask, o_flood}, 32'd0);
    irst_n = 1'b1;
    serve("mr_after", 12'h2A5, 3, 4'b0010, 4'b1000, 1'b0, 0, '0, '0);
    i_da_req = '0; idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
